// File: rtl/ins_dispatch_pkg.sv
// Shared constants, field layout and types for the instruction dispatcher.
package ins_dispatch_pkg;

    localparam int unsigned DEF_INST_W = 128;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned CFG_W      = 16;

    localparam logic [OP_W-1:0] OP_CONFIG  = 4'd0;
    localparam logic [OP_W-1:0] OP_BARRIER = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_ISSUE,
        ST_BARRIER
    } state_e;

    // Layer configuration as carried in the low bits of a CONFIG word.
    typedef struct packed {
        logic [3:0] in_ch_seg;
        logic [7:0] image_width;
        logic [3:0] layer_type;
    } cfg_t;

    function automatic logic is_dispatch(input logic [OP_W-1:0] op, input int unsigned n);
        return (op != OP_CONFIG) && (32'(op) <= n);
    endfunction

endpackage

// File: rtl/ins_dispatch_sem_counter.sv
// Saturating up/down counter; a simultaneous inc and dec nets to no change.
module ins_dispatch_sem_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o,
    output logic         unf_o
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == MAX) ovf_o = 1'b1;
            else              cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) unf_o = 1'b1;
            else             cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ins_dispatch.sv
// Instruction front-end: decodes host words, latches layer config and routes
// unit instructions under semaphore dependencies and barriers.
module ins_dispatch
    import ins_dispatch_pkg::*;
#(
    parameter int unsigned INST_W   = DEF_INST_W,
    parameter int unsigned NUM_UNIT = 3,
    parameter int unsigned SEM_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ins_valid,
    output logic                ins_ready,
    input  logic [INST_W-1:0]   ins,
    output logic [NUM_UNIT-1:0] unit_ins_valid,
    input  logic [NUM_UNIT-1:0] unit_ins_ready,
    output logic [INST_W-1:0]   unit_ins,
    input  logic [NUM_UNIT-1:0] unit_done,
    output logic [3:0]          layer_type,
    output logic [7:0]          image_width,
    output logic [3:0]          in_ch_seg,
    output logic                busy,
    output logic                err
);

    localparam int unsigned OP_MSB  = INST_W - 1;
    localparam int unsigned DEP_MSB = INST_W - 1 - OP_W;

    state_e state_q, state_d;

    logic [INST_W-1:0]   ins_q;
    cfg_t                cfg_q;
    logic                err_q, err_d;

    logic [OP_W-1:0]     op_in, op_q;
    logic [NUM_UNIT-1:0] dep_q, unit_sel, sem_nz, out_nz;
    logic                in_fire, in_cfg, in_disp, in_bar, in_ill;
    logic                deps_ok, hold_fire, issue_fire, out_clear_nxt;

    logic [SEM_W-1:0]    sem_q [NUM_UNIT];
    logic [SEM_W-1:0]    out_q [NUM_UNIT];
    logic [NUM_UNIT-1:0] sem_ovf, sem_unf, out_ovf, out_unf;

    // Decode of the incoming host word and of the latched dispatch word.
    always_comb begin
        op_in   = ins[OP_MSB -: OP_W];
        in_fire = ins_valid && ins_ready;
        in_cfg  = (op_in == OP_CONFIG);
        in_bar  = (op_in == OP_BARRIER);
        in_disp = is_dispatch(op_in, NUM_UNIT);
        in_ill  = !(in_cfg || in_bar || in_disp);

        op_q  = ins_q[OP_MSB -: OP_W];
        dep_q = ins_q[DEP_MSB -: NUM_UNIT];
        for (int unsigned j = 0; j < NUM_UNIT; j++) begin
            unit_sel[j] = (op_q == OP_W'(j + 1));
        end

        deps_ok    = &(~dep_q | sem_nz);
        hold_fire  = (state_q == ST_HOLD) && deps_ok;
        issue_fire = (state_q == ST_ISSUE) && |(unit_sel & unit_ins_ready);
    end

    // Barrier may release when every outstanding count is zero after this cycle's completions.
    always_comb begin
        out_clear_nxt = 1'b1;
        for (int unsigned j = 0; j < NUM_UNIT; j++) begin
            if (!((out_q[j] == '0) || ((out_q[j] == SEM_W'(1)) && unit_done[j]))) begin
                out_clear_nxt = 1'b0;
            end
        end
    end

    for (genvar j = 0; j < NUM_UNIT; j++) begin : g_unit
        ins_dispatch_sem_counter #(.W(SEM_W)) u_sem (
            .clk   (clk),
            .rst   (rst),
            .inc_i (unit_done[j]),
            .dec_i (hold_fire && dep_q[j]),
            .cnt_o (sem_q[j]),
            .ovf_o (sem_ovf[j]),
            .unf_o (sem_unf[j])
        );

        ins_dispatch_sem_counter #(.W(SEM_W)) u_out (
            .clk   (clk),
            .rst   (rst),
            .inc_i (issue_fire && unit_sel[j]),
            .dec_i (unit_done[j]),
            .cnt_o (out_q[j]),
            .ovf_o (out_ovf[j]),
            .unf_o (out_unf[j])
        );

        assign sem_nz[j] = (sem_q[j] != '0);
        assign out_nz[j] = (out_q[j] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire && in_disp)     state_d = ST_HOLD;
                else if (in_fire && in_bar) state_d = ST_BARRIER;
            end
            ST_HOLD:    if (deps_ok)       state_d = ST_ISSUE;
            ST_ISSUE:   if (issue_fire)    state_d = ST_IDLE;
            ST_BARRIER: if (out_clear_nxt) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ins_ready      = (state_q == ST_IDLE);
        unit_ins_valid = (state_q == ST_ISSUE) ? unit_sel : '0;
        busy           = (state_q != ST_IDLE) || (|out_nz);
        unit_ins       = ins_q;
        layer_type     = cfg_q.layer_type;
        image_width    = cfg_q.image_width;
        in_ch_seg      = cfg_q.in_ch_seg;
        err            = err_q;
    end

    // Sticky error: illegal opcode, counter overflow, or completion with nothing outstanding.
    assign err_d = err_q || (in_fire && in_ill) || (|sem_ovf) || (|sem_unf)
                 || (|out_ovf) || (|out_unf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_q <= '0;
            cfg_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (in_fire && in_disp) ins_q <= ins;
            if (in_fire && in_cfg)  cfg_q <= cfg_t'(ins[CFG_W-1:0]);
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_ins_dispatch.sv
// Directed self-checking bench for ins_dispatch (INST_W=128, NUM_UNIT=3, SEM_W=4).
module tb_ins_dispatch;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ins_valid = 1'b0;
    logic         ins_ready;
    logic [127:0] ins = '0;
    logic [2:0]   unit_ins_valid;
    logic [2:0]   unit_ins_ready = 3'b111;
    logic [127:0] unit_ins;
    logic [2:0]   unit_done = '0;
    logic [3:0]   layer_type;
    logic [7:0]   image_width;
    logic [3:0]   in_ch_seg;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    ins_dispatch #(.INST_W(128), .NUM_UNIT(3), .SEM_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .unit_ins_valid (unit_ins_valid),
        .unit_ins_ready (unit_ins_ready),
        .unit_ins       (unit_ins),
        .unit_done      (unit_done),
        .layer_type     (layer_type),
        .image_width    (image_width),
        .in_ch_seg      (in_ch_seg),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] low;
        logic [3:0]  e_lt;
        logic [7:0]  e_iw;
        logic [3:0]  e_cs;
        logic        e_err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [3:0] op, input logic [2:0] dep,
                                        input logic [15:0] low);
        logic [127:0] w;
        w          = '0;
        w[127:124] = op;
        w[123:121] = dep;
        w[95:64]   = 32'hDEAD_BEEF;
        w[15:0]    = low;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ins_valid = 1'b0;
        unit_done = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present one word for a single cycle; returns at the negedge after acceptance.
    task automatic send(input logic [127:0] w);
        ins_valid = 1'b1;
        ins       = w;
        tick();
        ins_valid = 1'b0;
        ins       = '0;
    endtask

    task automatic pulse_done(input logic [2:0] m);
        unit_done = m;
        tick();
        unit_done = '0;
    endtask

    // Dispatch with dependencies already met and ready high.
    task automatic dispatch_ready(input logic [3:0] op, input logic [2:0] dep);
        send(mk(op, dep, 16'h00AA));
        tick();
        tick();
    endtask

    initial begin
        logic [127:0] w;

        tbl[0] = '{4'd0,  16'h3A52, 4'h2, 8'hA5, 4'h3, 1'b0};
        tbl[1] = '{4'd0,  16'hFFFF, 4'hF, 8'hFF, 4'hF, 1'b0};
        tbl[2] = '{4'd0,  16'h0000, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[3] = '{4'd0,  16'h1234, 4'h4, 8'h23, 4'h1, 1'b0};
        tbl[4] = '{4'd7,  16'hBEEF, 4'h4, 8'h23, 4'h1, 1'b1};
        tbl[5] = '{4'd4,  16'h5555, 4'h4, 8'h23, 4'h1, 1'b1};

        do_reset();
        chk("rst_ins_ready", 128'(ins_ready), 128'(1'b1));
        chk("rst_busy",      128'(busy),      128'(1'b0));
        chk("rst_err",       128'(err),       128'(1'b0));
        chk("rst_valid",     128'(unit_ins_valid), 128'(3'b000));
        chk("rst_unit_ins",  unit_ins, '0);
        chk("rst_cfg",       128'({layer_type, image_width, in_ch_seg}), 128'(16'h0));

        // Config and illegal-opcode vectors, one word each.
        for (int i = 0; i < 6; i++) begin
            send(mk(tbl[i].op, 3'b000, tbl[i].low));
            chk($sformatf("tbl%0d_lt", i), 128'(layer_type),  128'(tbl[i].e_lt));
            chk($sformatf("tbl%0d_iw", i), 128'(image_width), 128'(tbl[i].e_iw));
            chk($sformatf("tbl%0d_cs", i), 128'(in_ch_seg),   128'(tbl[i].e_cs));
            chk($sformatf("tbl%0d_err", i), 128'(err),        128'(tbl[i].e_err));
            chk($sformatf("tbl%0d_valid", i), 128'(unit_ins_valid), 128'(3'b000));
            chk($sformatf("tbl%0d_rdy", i), 128'(ins_ready),  128'(1'b1));
        end

        // Dispatch to unit 1, no dependency.
        do_reset();
        w = mk(4'd2, 3'b000, 16'h1111);
        send(w);
        chk("disp_T1_valid", 128'(unit_ins_valid), 128'(3'b000));
        chk("disp_T1_rdy",   128'(ins_ready), 128'(1'b0));
        tick();
        chk("disp_T2_valid", 128'(unit_ins_valid), 128'(3'b010));
        chk("disp_T2_word",  unit_ins, w);
        tick();
        chk("disp_T3_rdy",   128'(ins_ready), 128'(1'b1));
        chk("disp_T3_valid", 128'(unit_ins_valid), 128'(3'b000));
        chk("disp_T3_busy",  128'(busy), 128'(1'b1));
        pulse_done(3'b010);
        chk("disp_done_busy", 128'(busy), 128'(1'b0));
        chk("disp_sem1",      128'(dut.sem_q[1]), 128'(4'd1));
        chk("disp_err",       128'(err), 128'(1'b0));

        // Dependency: unit 1 waits on unit 0 completion.
        dispatch_ready(4'd1, 3'b000);
        send(mk(4'd2, 3'b001, 16'h2222));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dep_stall%0d_rdy", i), 128'(ins_ready), 128'(1'b0));
            chk($sformatf("dep_stall%0d_valid", i), 128'(unit_ins_valid), 128'(3'b000));
            tick();
        end
        pulse_done(3'b001);
        chk("dep_d1_valid", 128'(unit_ins_valid), 128'(3'b000));
        tick();
        chk("dep_d2_valid", 128'(unit_ins_valid), 128'(3'b010));
        tick();
        chk("dep_sem0",  128'(dut.sem_q[0]), 128'(4'd0));
        chk("dep_sem1",  128'(dut.sem_q[1]), 128'(4'd1));
        chk("dep_rdy",   128'(ins_ready), 128'(1'b1));
        chk("dep_err",   128'(err), 128'(1'b0));

        // Barrier releases only in the cycle after the last completion.
        do_reset();
        dispatch_ready(4'd1, 3'b000);
        dispatch_ready(4'd1, 3'b000);
        send(mk(4'd15, 3'b000, 16'h0000));
        chk("bar_enter_rdy", 128'(ins_ready), 128'(1'b0));
        pulse_done(3'b001);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bar_wait%0d_rdy", i), 128'(ins_ready), 128'(1'b0));
            tick();
        end
        unit_done = 3'b001;
        chk("bar_last_rdy", 128'(ins_ready), 128'(1'b0));
        tick();
        unit_done = '0;
        chk("bar_release_rdy",  128'(ins_ready), 128'(1'b1));
        chk("bar_release_busy", 128'(busy), 128'(1'b0));
        chk("bar_err",          128'(err), 128'(1'b0));

        // Semaphore saturation: 16 legitimate completions on unit 2.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dispatch_ready(4'd3, 3'b000);
            pulse_done(3'b100);
            if (i == 14) chk("sem_sat15_err", 128'(err), 128'(1'b0));
        end
        chk("sem_ovf_err", 128'(err), 128'(1'b1));
        chk("sem_hold15",  128'(dut.sem_q[2]), 128'(4'd15));

        // Outstanding saturation: 16 dispatches to unit 0 with no completion.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dispatch_ready(4'd1, 3'b000);
            if (i == 14) chk("out_sat15_err", 128'(err), 128'(1'b0));
        end
        chk("out_ovf_err", 128'(err), 128'(1'b1));
        chk("out_hold15",  128'(dut.out_q[0]), 128'(4'd15));

        // Spurious completion with nothing outstanding.
        do_reset();
        pulse_done(3'b010);
        chk("spur_err",  128'(err), 128'(1'b1));
        chk("spur_busy", 128'(busy), 128'(1'b0));
        chk("spur_out1", 128'(dut.out_q[1]), 128'(4'd0));
        chk("spur_sem1", 128'(dut.sem_q[1]), 128'(4'd1));

        // Reset while an instruction is stuck in ISSUE.
        do_reset();
        unit_ins_ready = 3'b000;
        send(mk(4'd2, 3'b000, 16'h0BAD));
        tick();
        chk("mrst_pre_valid", 128'(unit_ins_valid), 128'(3'b010));
        #2 rst = 1'b1;
        #1;
        chk("mrst_async_valid", 128'(unit_ins_valid), 128'(3'b000));
        chk("mrst_async_rdy",   128'(ins_ready), 128'(1'b1));
        @(negedge clk);
        rst            = 1'b0;
        unit_ins_ready = 3'b111;
        tick();
        chk("mrst_busy",     128'(busy), 128'(1'b0));
        chk("mrst_err",      128'(err), 128'(1'b0));
        chk("mrst_unit_ins", unit_ins, '0);
        chk("mrst_out1",     128'(dut.out_q[1]), 128'(4'd0));
        chk("mrst_sem1",     128'(dut.sem_q[1]), 128'(4'd0));
        chk("mrst_valid",    128'(unit_ins_valid), 128'(3'b000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ins_dispatch.md
Name: ins_dispatch

Overview:
- Instruction front-end between the host instruction stream and the accelerator's execution units (DDR loader, PE array controller, DDR writer, ...).
- Decodes each instruction, latches layer configuration, and dispatches unit instructions to one of NUM_UNIT units.
- Enforces inter-unit dependencies with per-unit completion semaphores and supports a barrier.
- Parametrised successor of the fixed three-way top-level routing; unit count is generic.

Parameters:
- INST_W, 128, instruction width (>= 16 + 4 + NUM_UNIT).
- NUM_UNIT, 3, number of execution units (1..11).
- SEM_W, 4, width of each semaphore and outstanding counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ins_valid  in  1  host instruction valid
- ins_ready  out  1  host instruction ready
- ins  in  INST_W  host instruction
- unit_ins_valid  out  NUM_UNIT  per-unit instruction valid, one-hot or zero
- unit_ins_ready  in  NUM_UNIT  per-unit ready
- unit_ins  out  INST_W  shared instruction bus, full word forwarded unchanged
- unit_done  in  NUM_UNIT  per-unit one-cycle completion pulse, one per accepted instruction
- layer_type  out  4  latched config
- image_width  out  8  latched config
- in_ch_seg  out  4  latched config
- busy  out  1  high when state != IDLE or any outstanding != 0
- err  out  1  sticky error flag

Behaviour:
- Reset: async on rst high. State IDLE. All sem/outstanding counters 0. Outputs: unit_ins_valid=0, unit_ins=0, config outputs 0, err=0, busy=0, ins_ready=1.
- Field decode:
  - op = ins[INST_W-1 -: 4]
  - dep = ins[INST_W-5 -: NUM_UNIT]
  - op 0 = CONFIG: layer_type=ins[3:0], image_width=ins[11:4], in_ch_seg=ins[15:12].
  - op 1..NUM_UNIT = dispatch to unit op-1.
  - op 15 = BARRIER.
  - Any other op is illegal.
- FSM states: IDLE, HOLD, ISSUE, BARRIER. ins_ready = (state==IDLE) (Moore).
- IDLE, on ins_valid&ins_ready, latching the word into an internal register:
  - CONFIG: config outputs update next cycle; stay IDLE.
  - Dispatch: go to HOLD.
  - BARRIER: go to BARRIER.
  - Illegal: drop the word, set err, stay IDLE.
- HOLD: when sem[j] > 0 for every set bit j of dep, decrement each such sem[j] by 1 and go to ISSUE. Otherwise wait.
- ISSUE:
  - unit_ins_valid[op-1]=1; unit_ins=latched word, stable until handshake.
  - On the unit_ins_ready[op-1] handshake: outstanding[op-1]++, go to IDLE.
- BARRIER: go to IDLE in the cycle after all outstanding counters read 0.
- Latency: dispatch accepted at cycle T with deps satisfied gives unit_ins_valid high at T+2. With unit ready, the next ins_ready is at T+3.
- Counter updates:
  - unit_done[j]: sem[j]++ and outstanding[j]-- in the same cycle.
  - A same-cycle increment and decrement on one counter nets out; the result is the arithmetic sum.
- Saturation and errors:
  - sem saturates at 2^SEM_W-1; an extra increment sets err.
  - outstanding saturates at max; an extra increment sets err.
  - unit_done[j] with outstanding[j]==0 sets err and leaves outstanding at 0; sem[j] still increments.
- err is cleared only by rst.
- Reset mid-operation: any pending instruction is discarded and unit_ins_valid drops immediately.

Decomposition:
- Shared package GLOBAL_PARAM holds INST_W and opcode constants OP_CONFIG=0, OP_BARRIER=15, plus the field offset localparams.
- One natural sub-module: sem_counter (saturating up/down counter with overflow/underflow flags), instanced 2*NUM_UNIT times.

Test Plan:
- CONFIG word: op 0, low bits 0x3A52 -> next cycle layer_type=2, image_width=0xA5, in_ch_seg=3; no unit_ins_valid.
- Dispatch to unit 1 with dep=0, ready tied 1 -> unit_ins_valid=3'b010 at T+2; ins_ready back at T+3; busy high until unit_done[1], after which sem[1]=1.
- Dependency:
  - Stimulus: dispatch to unit 1 with dep=3'b001 while sem[0]=0.
  - Response: stalls in HOLD with ins_ready=0; unit_done[0] pulse at cycle 10 gives valid at cycle 12; sem[0] returns to 0.
- Barrier:
  - Stimulus: 2 dispatches to unit 0, then BARRIER; done pulses at cycles 20 and 25.
  - Response: ins_ready reasserts at cycle 26, not earlier.
- Errors:
  - Stimulus: op 7 with NUM_UNIT=3; 16 unit_done[2] pulses with no consumer; spurious unit_done while outstanding=0.
  - Response: each sets err; sem[2] holds at 15.
- Mid-operation reset: rst asserted while in ISSUE with ready=0 -> unit_ins_valid drops asynchronously; after release, state IDLE with all counters 0.
